shiftreg_seq_ctrl: RTL and testbench

- Sequencer and 2-way arbiter for the N-stage byte delay line (shiftreg datapath).
- Shares the line's single byte input between two requesters using valid/ready round-robin arbitration.
- Drives the line's shift enable and mirrors per-stage valid and source-tag bits.
- Presents tail-stage data as a valid/ready output stream, and supports a flush that drains the line with bubbles.

---
 rtl/shiftreg_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_shiftreg_seq_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_seq_ctrl.sv
// shiftreg_seq_ctrl: sequencer and two-way arbiter for an N-stage byte delay line.
// Two requesters share the line's single byte input. Arbitration is round-robin.
// The block mirrors per-stage valid/tag bits, presents the tail stage as a
// valid/ready stream, and drains partial bursts with a flush.
// Build option: define SRCTL_FIXED_PRIO_EN for fixed priority, where requester 0
// always wins and no last-grant state is kept.
module shiftreg_seq_ctrl #(
    parameter int N     = 20,
    parameter int OCC_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    input  logic [7:0]       req_data0,
    input  logic [7:0]       req_data1,
    output logic [1:0]       req_ready,
    input  logic             flush,
    output logic             sr_shift_en,
    output logic [7:0]       sr_data_in,
    input  logic [7:0]       sr_data_out,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     vld_q, vld_d;
    logic [N-1:0]     tag_q, tag_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic       stall;
    logic       grant_ok;
    logic       gnt_id;
    logic [1:0] ready;
    logic       accept;
    logic       xfer;
    logic       shift;

`ifndef SRCTL_FIXED_PRIO_EN
    logic last_grant_q, last_grant_d;
`endif

    // Arbitration. The grant is held off during reset, during a flush, and
    // while the tail is blocked by downstream.
    always_comb begin
        stall    = vld_q[N-1] & ~out_ready;
        grant_ok = rst_n & (state_q != FLUSH) & ~stall;
        gnt_id   = 1'b0;
        if (req_valid == 2'b10) begin
            gnt_id = 1'b1;
        end else if (req_valid == 2'b11) begin
`ifdef SRCTL_FIXED_PRIO_EN
            gnt_id = 1'b0;
`else
            gnt_id = ~last_grant_q;
`endif
        end
        ready = 2'b00;
        if (grant_ok) ready[gnt_id] = req_valid[gnt_id];
        accept = |(req_valid & ready);
    end

    // Shift decision. A consumed tail is always replaced. When nothing is
    // accepted, a bubble is injected. FLUSH keeps shifting until the line is empty.
    always_comb begin
        xfer  = vld_q[N-1] & out_ready;
        shift = ~stall & (accept | vld_q[N-1] | ((state_q == FLUSH) & (occ_q != '0)));
    end

    // Next-state values for the stage mirror, occupancy and arbitration history.
    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        if (shift) begin
            vld_d = {vld_q[N-2:0], accept};
            tag_d = {tag_q[N-2:0], accept & gnt_id};
        end
        occ_d = occ_q + OCC_W'(accept) - OCC_W'(xfer);
`ifndef SRCTL_FIXED_PRIO_EN
        last_grant_d = accept ? gnt_id : last_grant_q;
`endif
    end

    // FSM next state. A flush is honoured only if the line would still hold data.
    // An accept in the same cycle as a flush completes before the drain starts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (flush && occ_d != '0) state_d = FLUSH;
                else if (accept)          state_d = RUN;
            end
            RUN: begin
                if (flush && occ_d != '0)      state_d = FLUSH;
                else if (occ_d == '0 && !accept) state_d = IDLE;
            end
            FLUSH: begin
                if (occ_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers. The initial last grant is 1, so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vld_q   <= '0;
            tag_q   <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            tag_q   <= tag_d;
            occ_q   <= occ_d;
        end
    end

`ifndef SRCTL_FIXED_PRIO_EN
    // Round-robin history register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= 1'b1;
        else        last_grant_q <= last_grant_d;
    end
`endif

    // Output drive.
    always_comb begin
        req_ready   = ready;
        sr_shift_en = shift;
        sr_data_in  = accept ? (gnt_id ? req_data1 : req_data0) : 8'h00;
        out_valid   = vld_q[N-1];
        out_src     = tag_q[N-1];
        out_data    = sr_data_out;
        occupancy   = occ_q;
        busy        = (state_q != IDLE);
    end

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Bench for shiftreg_seq_ctrl. A behavioural byte delay line stands in for the
// datapath. The reference model is a queue of in-flight bytes, each with the
// number of shifts it has seen. A byte is visible at the tail once it has seen N shifts.
module tb_shiftreg_seq_ctrl;
    localparam int N     = 20;
    localparam int OCC_W = $clog2(N + 1);
`ifdef SRCTL_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [7:0]       req_data0, req_data1;
    logic [1:0]       req_ready;
    logic             flush;
    logic             sr_shift_en;
    logic [7:0]       sr_data_in;
    logic [7:0]       sr_data_out;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_src;
    logic             out_ready;
    logic [OCC_W-1:0] occupancy;
    logic             busy;

    shiftreg_seq_ctrl #(.N(N), .OCC_W(OCC_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data0(req_data0),
        .req_data1(req_data1), .req_ready(req_ready), .flush(flush),
        .sr_shift_en(sr_shift_en), .sr_data_in(sr_data_in), .sr_data_out(sr_data_out),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .occupancy(occupancy), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in datapath: an N-byte shift line, reset together with the controller.
    logic [7:0] line [N];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) line[i] <= 8'h00;
        end else if (sr_shift_en) begin
            line[0] <= sr_data_in;
            for (int i = 1; i < N; i++) line[i] <= line[i-1];
        end
    end
    assign sr_data_out = line[N-1];

    // Reference model state.
    typedef struct { logic [7:0] d; logic s; int age; } item_t;
    item_t mq[$];
    bit    m_busy, m_flushing, m_last;

    int checks = 0;
    int failures = 0;
    logic [1:0] seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_busy = 0; m_flushing = 0; m_last = 1;
    endtask

    // One clock cycle. This task starts and ends on a negedge.
    task automatic cyc(input logic [1:0] rv, input logic [7:0] a, input logic [7:0] b,
                       input logic fl, input logic ordy, output logic [1:0] rdy_seen);
        bit head_out, stall, acc, xfer, shift, win;
        logic [1:0] exp_rdy;
        item_t it;
        req_valid = rv; req_data0 = a; req_data1 = b; flush = fl; out_ready = ordy;
        #2;
        head_out = (mq.size() > 0) && (mq[0].age == N);
        stall    = head_out && !ordy;
        exp_rdy  = 2'b00;
        win      = 1'b0;
        if (!m_flushing && !stall && rv != 2'b00) begin
            if (rv == 2'b11) win = FIXED ? 1'b0 : ~m_last;
            else             win = rv[1];
            exp_rdy[win] = 1'b1;
        end
        acc   = (exp_rdy != 2'b00);
        xfer  = head_out && ordy;
        shift = !stall && (acc || head_out || (m_flushing && mq.size() > 0));
        rdy_seen = req_ready;
        chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
        chk("shift_en", {31'd0, sr_shift_en}, {31'd0, shift});
        chk("sr_data_in", {24'd0, sr_data_in}, acc ? {24'd0, (win ? b : a)} : 32'd0);
        chk("out_valid", {31'd0, out_valid}, {31'd0, head_out});
        chk("occupancy", {{(32-OCC_W){1'b0}}, occupancy}, mq.size());
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        if (head_out) begin
            chk("out_data", {24'd0, out_data}, {24'd0, mq[0].d});
            chk("out_src", {31'd0, out_src}, {31'd0, mq[0].s});
        end
        @(posedge clk);
        if (xfer) void'(mq.pop_front());
        if (shift) foreach (mq[i]) mq[i].age++;
        if (acc) begin
            it.d = win ? b : a; it.s = win; it.age = 1;
            mq.push_back(it);
            m_last = win;
        end
        if (m_flushing) begin
            if (mq.size() == 0) begin m_flushing = 0; m_busy = 0; end
        end else if (fl && mq.size() != 0) begin
            m_flushing = 1; m_busy = 1;
        end else if (acc) begin
            m_busy = 1;
        end else if (mq.size() == 0) begin
            m_busy = 0;
        end
        @(negedge clk);
    endtask

    // Apply reset for one edge and check the outputs while reset is low.
    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b11; req_data0 = 8'hA5; req_data1 = 8'h5A; flush = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_occupancy", {{(32-OCC_W){1'b0}}, occupancy}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_shift_en", {31'd0, sr_shift_en}, 32'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int max_cyc);
        int k = 0;
        while (m_busy && k < max_cyc) begin
            cyc(2'b00, 8'h00, 8'h00, 1'b1, ($urandom_range(0, 3) != 0), seen);
            k++;
        end
        chk("drain_done_busy", {31'd0, busy}, 32'd0);
        chk("drain_done_occ", {{(32-OCC_W){1'b0}}, occupancy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 0; req_data0 = 0; req_data1 = 0; flush = 0; out_ready = 1;
        @(negedge clk);
        do_reset();

        // Both requesters are valid from reset. Round-robin alternates; fixed priority always picks 0.
        for (int k = 0; k < 4; k++) begin
            cyc(2'b11, 8'h10 + 8'(k), 8'h20 + 8'(k), 1'b0, 1'b1, seen);
            chk("alt_grant", {30'd0, seen}, (FIXED || (k % 2 == 0)) ? 32'd1 : 32'd2);
        end
        drain(100);

        // Fill the line from requester 0 with bytes 1..20, then accept a 21st byte.
        for (int k = 1; k <= N; k++) cyc(2'b01, 8'(k), 8'hEE, 1'b0, 1'b1, seen);
        chk("full_occ", {{(32-OCC_W){1'b0}}, occupancy}, N);
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        chk("full_out_data", {24'd0, out_data}, 32'd1);
        chk("full_out_src", {31'd0, out_src}, 32'd0);
        cyc(2'b01, 8'd21, 8'hEE, 1'b0, 1'b1, seen);
        chk("full_occ_after", {{(32-OCC_W){1'b0}}, occupancy}, N);

        // Stall the full line for 10 cycles while both requesters press.
        for (int k = 0; k < 10; k++) begin
            cyc(2'b11, 8'($urandom), 8'($urandom), 1'b0, 1'b0, seen);
            chk("stall_tail", {24'd0, out_data}, 32'd2);
        end
        for (int k = 0; k < 6; k++) cyc(2'b11, 8'($urandom), 8'($urandom), 1'b0, 1'b1, seen);
        chk("release_occ", {{(32-OCC_W){1'b0}}, occupancy}, N);
        drain(200);

        // Reset in the middle of a RUN burst with seven bytes held.
        for (int k = 0; k < 7; k++) cyc(2'b10, 8'h00, 8'h30 + 8'(k), 1'b0, 1'b1, seen);
        chk("pre_rst_occ", {{(32-OCC_W){1'b0}}, occupancy}, 32'd7);
        do_reset();

        // Accept five bytes, pulse flush, and let the bytes emerge in order.
        for (int k = 0; k < 5; k++) cyc(2'b01, 8'h40 + 8'(k), 8'h00, 1'b0, 1'b1, seen);
        cyc(2'b00, 8'h00, 8'h00, 1'b1, 1'b1, seen);
        cyc(2'b11, 8'h77, 8'h88, 1'b0, 1'b1, seen);
        chk("flush_no_grant", {30'd0, seen}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd1);
        drain(100);

        // A flush on an empty line is ignored.
        cyc(2'b00, 8'h00, 8'h00, 1'b1, 1'b1, seen);
        chk("empty_flush_busy", {31'd0, busy}, 32'd0);
        cyc(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, seen);

        // Randomised traffic, with occasional flushes and downstream back-pressure.
        for (int k = 0; k < 600; k++) begin
            cyc(2'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 3) != 0), seen);
        end
        drain(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
